// File: rtl/dma_priority_resolver.sv
// Four-channel DMA request arbiter: fixed or rotating priority, one-hot grant to the
// timing FSM, and DACK generation while the granted channel is serviced.
`timescale 1ns/1ps
module dma_priority_resolver #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NCH-1:0]         DREQ,
  input  logic                   dreqSense,
  input  logic                   dackSense,
  input  logic                   rotatingPriority,
  input  logic                   controllerDisable,
  input  logic [NCH-1:0]         maskReg,
  input  logic [NCH-1:0]         swReq,
  input  logic                   IDLE_CYCLE,
  input  logic                   validDACK,
  input  logic                   serviceDone,
  output logic [NCH-1:0]         VALID_DREQ,
  output logic [NCH-1:0]         DACK,
  output logic [$clog2(NCH)-1:0] activeChannel,
  output logic                   grantValid,
  output logic [NCH-1:0]         swReqClr
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_PEND = 2'd1,
    ARB_SVC  = 2'd2
  } arb_state_t;

  arb_state_t r_state;
  arb_state_t w_state_next;

  logic [NCH-1:0] r_sync [SYNC_STAGES];
  logic [NCH-1:0] w_sync_req;
  logic [NCH-1:0] w_eff_req;

  logic [CW-1:0]  r_hi_pri;
  logic [CW-1:0]  w_hi_pri;
  logic [NCH-1:0] w_rot_req;
  logic [CW-1:0]  w_win_off;
  logic           w_any_req;
  logic [CW-1:0]  w_winner;
  logic [NCH-1:0] w_win_onehot;

  logic [CW-1:0]  r_active;
  logic [NCH-1:0] w_ac_onehot;
  logic [NCH-1:0] r_valid;
  logic           r_grant;
  logic [NCH-1:0] r_dack;

  logic [CW-1:0]  w_active_next;
  logic [NCH-1:0] w_valid_next;
  logic           w_grant_next;
  logic           w_dack_on_next;
  logic           w_rotate;
  logic [NCH-1:0] w_sw_clr;

  // DREQ pin synchroniser; sense inversion is applied after the last stage.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= DREQ;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync_req = r_sync[SYNC_STAGES-1] ^ {NCH{dreqSense}};
  assign w_eff_req  = (w_sync_req & ~maskReg) | swReq;

  // Fixed mode ignores the stored pointer immediately, not one edge later.
  assign w_hi_pri = rotatingPriority ? r_hi_pri : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      assign w_rot_req[gi]    = w_eff_req[w_hi_pri + CW'(gi)];
      assign w_win_onehot[gi] = (w_winner == CW'(gi));
      assign w_ac_onehot[gi]  = (r_active == CW'(gi));
    end
  endgenerate

  // Lowest rotated offset with a request is the highest-priority requester.
  always_comb begin
    w_win_off = '0;
    w_any_req = 1'b0;
    for (int k = NCH-1; k >= 0; k--) begin
      if (w_rot_req[k]) begin
        w_win_off = CW'(k);
        w_any_req = 1'b1;
      end
    end
  end

  assign w_winner = w_hi_pri + w_win_off;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (IDLE_CYCLE && !controllerDisable && w_any_req) begin
          w_state_next = ARB_PEND;
        end
      end
      ARB_PEND: begin
        if (validDACK) begin
          w_state_next = ARB_SVC;
        end else if (!w_eff_req[r_active]) begin
          w_state_next = ARB_IDLE;
        end
      end
      ARB_SVC: begin
        if (serviceDone) begin
          w_state_next = ARB_IDLE;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_active_next  = r_active;
    w_valid_next   = '0;
    w_grant_next   = 1'b0;
    w_dack_on_next = 1'b0;
    w_rotate       = 1'b0;
    w_sw_clr       = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_state_next == ARB_PEND) begin
          w_active_next = w_winner;
          w_valid_next  = w_win_onehot;
          w_grant_next  = 1'b1;
        end
      end
      ARB_PEND: begin
        if (w_state_next != ARB_IDLE) begin
          w_valid_next   = w_ac_onehot;
          w_grant_next   = 1'b1;
          w_dack_on_next = (w_state_next == ARB_SVC);
        end
      end
      ARB_SVC: begin
        if (serviceDone) begin
          w_rotate = 1'b1;
          w_sw_clr = w_ac_onehot & swReq;
        end else begin
          w_valid_next   = w_ac_onehot;
          w_grant_next   = 1'b1;
          w_dack_on_next = 1'b1;
        end
      end
      default: begin
        w_valid_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_active <= '0;
      r_valid  <= '0;
      r_grant  <= 1'b0;
      r_dack   <= '1;
    end else begin
      r_active <= w_active_next;
      r_valid  <= w_valid_next;
      r_grant  <= w_grant_next;
      if (w_dack_on_next) begin
        r_dack <= dackSense ? w_ac_onehot : ~w_ac_onehot;
      end else begin
        r_dack <= {NCH{~dackSense}};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || !rotatingPriority) begin
      r_hi_pri <= '0;
    end else if (w_rotate) begin
      r_hi_pri <= r_active + CW'(1);
    end
  end

  assign VALID_DREQ    = r_valid;
  assign DACK          = r_dack;
  assign activeChannel = r_active;
  assign grantValid    = r_grant;
  // Combinational so the request register clears on the same edge we return to idle.
  assign swReqClr      = w_sw_clr;

endmodule

// File: tb/tb_dma_priority_resolver.sv
// Randomised scoreboard bench for dma_priority_resolver: driver pushes expected events,
// a negedge monitor pops and compares whenever the DUT shows a grant/DACK/clear/release.
`timescale 1ns/1ps
module tb_dma_priority_resolver;

  localparam int SS = 2;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic       dreqSense, dackSense, rotatingPriority, controllerDisable;
  logic [3:0] maskReg, swReq;
  logic       IDLE_CYCLE, validDACK, serviceDone;
  logic [3:0] VALID_DREQ, DACK, swReqClr;
  logic [1:0] activeChannel;
  logic       grantValid;

  dma_priority_resolver #(.NCH(4), .SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ),
    .dreqSense(dreqSense), .dackSense(dackSense),
    .rotatingPriority(rotatingPriority), .controllerDisable(controllerDisable),
    .maskReg(maskReg), .swReq(swReq),
    .IDLE_CYCLE(IDLE_CYCLE), .validDACK(validDACK), .serviceDone(serviceDone),
    .VALID_DREQ(VALID_DREQ), .DACK(DACK), .activeChannel(activeChannel),
    .grantValid(grantValid), .swReqClr(swReqClr)
  );

  always #5 CLK = ~CLK;

  localparam int EV_GRANT = 0, EV_DACK = 1, EV_SWCLR = 2, EV_REL = 3;
  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  ev_t  exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   hp      = 0;
  int   txn_no  = 0;
  logic prev_gv = 1'b0;
  logic [3:0] prev_dack = 4'hF;

  task automatic push_ev(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic mon_check(input int kind, input logic [7:0] val);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL mon_unexpected: got kind %0d val %h expected nothing", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val) begin
        n_fail++;
        $display("FAIL mon_event: got kind %0d val %h expected kind %0d val %h",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (grantValid && !prev_gv) mon_check(EV_GRANT, {2'b00, activeChannel, VALID_DREQ});
    if ((grantValid || prev_gv) && DACK != prev_dack) mon_check(EV_DACK, {4'h0, DACK});
    if (swReqClr != 4'h0) mon_check(EV_SWCLR, {4'h0, swReqClr});
    if (!grantValid && prev_gv) mon_check(EV_REL, {4'h0, VALID_DREQ});
    prev_gv   = grantValid;
    prev_dack = DACK;
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  // Reference arbitration: first requesting channel walking round from the pointer.
  function automatic int winner(input logic [3:0] eff, input int ptr);
    for (int i = 0; i < 4; i++) begin
      if (eff[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] grant_val(input int ch);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    return {2'b00, 2'(ch), oh};
  endfunction

  task automatic reset_from_pend(input bit ks);
    if ({4{~ks}} != 4'hF) push_ev(EV_DACK, 8'h0F);
    push_ev(EV_REL, 8'h00);
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    hp = 0;
  endtask

  task automatic run_txn(input bit rot, input bit dis, input bit ds, input bit ks,
                         input logic [3:0] mask, input logic [3:0] sw, input logic [3:0] act,
                         input int wd_mode, input bit idle_at_done, input bit lat_check,
                         input bit rst_in_svc);
    logic [3:0] eff, clr, oh;
    int ch, n;
    IDLE_CYCLE = 0; validDACK = 0; serviceDone = 0;
    rotatingPriority = rot; controllerDisable = dis;
    dreqSense = ds; dackSense = ks; maskReg = mask; swReq = sw;
    if (!rot) hp = 0;
    eff = (act & ~mask) | sw;
    ch  = dis ? -1 : winner(eff, hp);
    txn_no++;
    $display("[TB] txn %0d rot=%0b dis=%0b ds=%0b ks=%0b eff=%b hiPri=%0d expect_ch=%0d wd=%0d",
             txn_no, rot, dis, ds, ks, eff, hp, ch, wd_mode);
    if (lat_check) begin
      DREQ = {4{ds}};
      repeat (SS + 2) cycle();
      IDLE_CYCLE = 1;
      push_ev(EV_GRANT, grant_val(ch));
      DREQ = act ^ {4{ds}};
      n = 0;
      do begin
        cycle();
        n++;
      end while (!grantValid && n < 10);
      chk("pin_to_grant_latency", n, SS + 1);
      IDLE_CYCLE = 0;
    end else begin
      DREQ = act ^ {4{ds}};
      serviceDone = 1'($urandom_range(0, 1));
      cycle();
      serviceDone = 0;
      repeat (SS) cycle();
      chk("idle_dack", DACK, {4{~ks}});
      if (ch < 0) begin
        IDLE_CYCLE = 1;
        repeat (3) cycle();
        IDLE_CYCLE = 0;
        chk("no_grant", grantValid, 0);
        return;
      end
      push_ev(EV_GRANT, grant_val(ch));
      IDLE_CYCLE = 1;
      cycle();
      IDLE_CYCLE = 0;
    end
    oh = 4'b0001 << ch;

    repeat ($urandom_range(0, 2)) begin
      serviceDone = 1'($urandom_range(0, 1));
      cycle();
    end
    serviceDone = 0;
    if (wd_mode != 0) begin
      maskReg[ch] = 1'b1;
      swReq[ch]   = 1'b0;
    end
    if (wd_mode == 1) begin
      push_ev(EV_REL, 8'h00);
      cycle();
      return;
    end

    validDACK = 1;
    push_ev(EV_DACK, {4'h0, (ks ? oh : ~oh)});
    cycle();
    validDACK = 0;
    if (rst_in_svc) begin
      cycle();
      push_ev(EV_DACK, 8'h0F);
      push_ev(EV_REL, 8'h00);
      RESET = 1'b1;
      cycle();
      RESET = 1'b0;
      hp = 0;
      return;
    end

    repeat ($urandom_range(1, 4)) begin
      maskReg = 4'($urandom);
      controllerDisable = ($urandom_range(0, 3) == 0);
      if (!idle_at_done) DREQ = 4'($urandom);
      cycle();
    end
    serviceDone = 1;
    IDLE_CYCLE  = idle_at_done;
    clr = swReq & oh;
    if (clr != 4'h0) push_ev(EV_SWCLR, {4'h0, clr});
    push_ev(EV_DACK, {4'h0, {4{~ks}}});
    push_ev(EV_REL, 8'h00);
    cycle();
    serviceDone = 0;
    swReq = swReq & ~clr;
    hp = rot ? (ch + 1) % 4 : 0;

    if (idle_at_done) begin
      eff = (act & ~maskReg) | swReq;
      ch  = controllerDisable ? -1 : winner(eff, hp);
      if (ch >= 0) push_ev(EV_GRANT, grant_val(ch));
      cycle();
      IDLE_CYCLE = 0;
      if (ch >= 0) reset_from_pend(ks);
    end else begin
      IDLE_CYCLE = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1; DREQ = 4'h0; dreqSense = 0; dackSense = 0; rotatingPriority = 0;
    controllerDisable = 0; maskReg = 4'h0; swReq = 4'h0;
    IDLE_CYCLE = 0; validDACK = 0; serviceDone = 0;
    repeat (3) cycle();
    chk("reset_valid_dreq", VALID_DREQ, 0);
    chk("reset_grant_valid", grantValid, 0);
    chk("reset_dack", DACK, 4'hF);
    chk("reset_active_channel", activeChannel, 0);
    chk("reset_sw_req_clr", swReqClr, 0);
    RESET = 0;
    cycle();

    // Fixed priority, channel 1 wins twice.
    run_txn(0, 0, 0, 0, 4'h0, 4'h0, 4'b1010, 0, 0, 0, 0);
    run_txn(0, 0, 0, 0, 4'h0, 4'h0, 4'b1010, 0, 0, 0, 0);
    // Rotating with all requesting: ch0..ch3, then back to ch0.
    for (int i = 0; i < 5; i++) run_txn(1, 0, 0, 0, 4'h0, 4'h0, 4'b1111, 0, 0, 0, 0);
    // Masked hardware request ignored; software request is not maskable.
    run_txn(0, 0, 0, 0, 4'b0001, 4'h0, 4'b0001, 0, 0, 0, 0);
    run_txn(0, 0, 0, 0, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0);
    // Inverted senses: ch2 low on the pin, DACK active high.
    run_txn(0, 0, 1, 1, 4'h0, 4'h0, 4'b0100, 0, 0, 0, 0);
    // Withdrawal in PEND on ch3 leaves the pointer alone.
    run_txn(1, 0, 0, 0, 4'h0, 4'h0, 4'b1000, 1, 0, 0, 0);
    run_txn(1, 0, 0, 0, 4'h0, 4'h0, 4'b1111, 0, 0, 0, 0);
    // Withdrawal together with validDACK: service proceeds.
    run_txn(1, 0, 0, 0, 4'h0, 4'h0, 4'b0110, 2, 0, 0, 0);
    // Reset during service.
    run_txn(0, 0, 0, 0, 4'h0, 4'h0, 4'b0010, 0, 0, 0, 1);
    // Pin-to-grant latency.
    run_txn(0, 0, 0, 0, 4'h0, 4'h0, 4'b0100, 0, 0, 1, 0);
    // serviceDone with IDLE_CYCLE held: regrant one cycle later under the new pointer.
    run_txn(1, 0, 0, 0, 4'h0, 4'h0, 4'b1111, 0, 1, 0, 0);
    // Controller disabled: nothing granted.
    run_txn(0, 1, 0, 0, 4'h0, 4'h0, 4'b1111, 0, 0, 0, 0);

    for (int t = 0; t < 200; t++) begin
      int r;
      logic [3:0] sw;
      r  = $urandom_range(0, 7);
      sw = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      run_txn(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom), sw, 4'($urandom),
              (r == 6) ? 1 : (r == 7) ? 2 : 0,
              1'($urandom_range(0, 1)), 1'b0, ($urandom_range(0, 15) == 0));
    end

    repeat (5) cycle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_priority_resolver.md
Name: dma_priority_resolver

Overview:
- Arbitrates the four DMA channel requests (hardware DREQ and software request register) and picks one channel to service next.
- Presents the winner to the timing-control FSM as a one-hot VALID_DREQ and drives the DACK lines while that channel is serviced.
- Supports fixed priority and rotating priority, controlled by the command register.
- Sits between the pins/datapath registers and the timing-control FSM.

Parameters:
- NCH, 4, number of channels; only 4 is supported.
- SYNC_STAGES, 1, number of DREQ input register stages (1 or 2).

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- DREQ  in  4  raw channel request pins.
- dreqSense  in  1  commandReg[6]: 0 = DREQ active high, 1 = active low.
- dackSense  in  1  commandReg[7]: 0 = DACK active low, 1 = active high.
- rotatingPriority  in  1  commandReg[4]: 0 = fixed, 1 = rotating.
- controllerDisable  in  1  commandReg[2]: blocks new grants.
- maskReg  in  4  per-channel mask; 1 = masked.
- swReq  in  4  software request register bits; never masked.
- IDLE_CYCLE  in  1  timing FSM is in SI.
- validDACK  in  1  timing FSM has entered the active cycle (S1).
- serviceDone  in  1  one-cycle pulse at end of service (S4 or EOP).
- VALID_DREQ  out  4  one-hot granted request to the timing FSM.
- DACK  out  4  channel acknowledge pins, polarity per dackSense.
- activeChannel  out  2  index of the granted channel.
- grantValid  out  1  a grant is held.
- swReqClr  out  4  one-cycle pulse clearing the serviced channel's swReq bit.

Behaviour:
- Request sampling:
  - DREQ passes through SYNC_STAGES registers, then is XORed with {4{dreqSense}}.
  - effReq = (syncReq & ~maskReg) | swReq.
- Priority:
  - A 2-bit pointer hiPri names the highest-priority channel; order is hiPri, hiPri+1, ... modulo 4.
  - Fixed mode: hiPri is forced to 0 every cycle.
  - Rotating mode: at serviceDone, hiPri <= activeChannel+1 (mod 4), so the serviced channel drops to lowest.
- FSM states: ARB_IDLE, ARB_PEND, ARB_SVC.
  - ARB_IDLE: if IDLE_CYCLE & ~controllerDisable & |effReq, latch the winner into activeChannel and go to ARB_PEND. Otherwise stay.
  - ARB_PEND: VALID_DREQ = one-hot(activeChannel), grantValid = 1.
    - validDACK -> ARB_SVC.
    - Else if effReq[activeChannel] == 0 (request withdrawn) -> ARB_IDLE; no rotation, no swReqClr.
  - ARB_SVC: VALID_DREQ held, DACK[activeChannel] asserted.
    - Mask or DREQ changes are ignored until serviceDone; the transfer always completes.
    - serviceDone -> ARB_IDLE, apply rotation, pulse swReqClr[activeChannel] if swReq[activeChannel] == 1.
- Outputs:
  - VALID_DREQ, grantValid and activeChannel are registered.
  - VALID_DREQ = 0 and grantValid = 0 in ARB_IDLE.
  - DACK is registered: asserted level = dackSense; every non-asserted bit = ~dackSense.
- Latency:
  - A request present at sync-stage output with IDLE_CYCLE = 1 gives VALID_DREQ on the next edge.
  - DREQ pin to VALID_DREQ is SYNC_STAGES+1 cycles.
  - DACK asserts on the edge after validDACK is sampled and deasserts on the edge after serviceDone.
- Boundary cases:
  - Simultaneous requests: the highest priority under the current hiPri wins.
  - serviceDone together with new requests: return to ARB_IDLE first; a new grant is issued only on the following cycle, using the updated hiPri.
  - controllerDisable set mid-service: the current service finishes; no further grants.
  - serviceDone seen in ARB_IDLE or ARB_PEND: ignored.
  - validDACK and request withdrawal in the same cycle: validDACK wins.
- Reset:
  - FSM to ARB_IDLE, hiPri = 0, activeChannel = 0, VALID_DREQ = 0, grantValid = 0, swReqClr = 0.
  - DACK = 4'b1111 (inactive for the default dackSense = 0); sync registers cleared.
  - A reset in any state aborts immediately.

Test Plan:
- Fixed priority, DREQ = 4'b1010, IDLE_CYCLE = 1 -> VALID_DREQ = 4'b0010, activeChannel = 1. After service, with DREQ still 4'b1010, channel 1 wins again.
- Rotating priority, DREQ = 4'b1111, four full services -> grant order ch0, ch1, ch2, ch3; hiPri = 0 after the fourth serviceDone.
- maskReg = 4'b0001, DREQ = 4'b0001, swReq = 4'b0000 -> no grant. Then swReq = 4'b0001 -> grant ch0; swReqClr = 4'b0001 pulses at serviceDone.
- dreqSense = 1, dackSense = 1, DREQ = 4'b1011 (ch2 low = active) -> grant ch2; after validDACK, DACK = 4'b0100.
- ARB_PEND on ch3, DREQ[3] dropped before validDACK -> back to ARB_IDLE, VALID_DREQ = 0, hiPri unchanged.
- RESET asserted during ARB_SVC -> next edge: VALID_DREQ = 0, DACK = 4'b1111, grantValid = 0, FSM in ARB_IDLE.
